// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter and its digit adjuster.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;

    // Any code above 9 renders as all segments off in the downstream decoder.
    localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, no carry out.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, with
// optional leading-zero blanking of the registered result.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = DIGIT_W * DIGITS;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_next;
    logic [SCR_W-1:0]   bcd_blanked;
    logic               leading;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The top bit of the adjusted scratch falls off here; it is always 0 when
    // DIGITS is large enough for WIDTH.
    always_comb begin
        scratch_next = (scratch_adj << 1) | {{(SCR_W-1){1'b0}}, shift_q[WIDTH-1]};
    end

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values assigned above them (here, the running 'leading' flag).
    always_comb begin
        bcd_blanked = scratch_next;
        leading     = 1'b1;
        if (BLANK_LZ) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (leading && (scratch_next[i*DIGIT_W +: DIGIT_W] == '0)) begin
                    bcd_blanked[i*DIGIT_W +: DIGIT_W] = BCD_BLANK;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    end

    // NOTE: every *_d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = scratch_next;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = bcd_blanked;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values; all registers, scratch included, reset to zero so an
    // aborted conversion leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        busy    = (state_q == ST_SHIFT);
        done    = done_q;
        bcd_out = bcd_q;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one input bit per clock.
- Sits directly upstream of the 7-segment decoder bank. Each 4-bit digit of bcd_out drives one display_7_seg instance.
- Typical source: a datapath value such as the PC, an ALU result or register-file read data, for on-board display.
- Optional leading-zero blanking emits code 4'hF. The downstream decoder maps any code >9 to all segments off.

Parameters:
- WIDTH, 16, bit width of the binary input.
- DIGITS, 5, number of BCD digits out. Must satisfy 10^DIGITS > 2^WIDTH-1; the default covers 0..65535.
- BLANK_LZ, 1, if 1, leading-zero digits are replaced by 4'hF. Digit 0 is never blanked.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  WIDTH  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd_out has just been updated.
- bcd_out  output  4*DIGITS  BCD digits. Digit k is at [4k+3:4k]; digit 0 is the least significant.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, shift counter=0, scratch registers=0.
  - bcd_out=0 means all digits show 0. Blanking is applied only at result load, so it does not affect the reset value.
- States:
  - IDLE: busy=0. On a clk edge with start=1:
    - capture bin_in into the shift register;
    - clear the BCD scratch register;
    - set counter=WIDTH;
    - go to SHIFT.
  - SHIFT: busy=1. Each edge performs one iteration:
    - every scratch digit >=5 gets +3, all digits in parallel, 4-bit result;
    - then {scratch, shift register} shifts left by 1, with the MSB of the shift register entering scratch bit 0;
    - counter decrements.
    - On the edge where counter goes 1->0: load bcd_out from the final scratch value (blanking applied), pulse done, go to IDLE.
- Latency: start accepted at edge T0. Shifts occur at edges T1..TWIDTH. bcd_out changes and done=1 on edge TWIDTH, and done falls at edge TWIDTH+1.
- busy timing: busy=1 from after T0 until TWIDTH. done and busy are never high in the same cycle.
- start while busy: ignored, with no effect on the in-flight conversion. bin_in changes during SHIFT are ignored.
- Back-to-back: start=1 during the done cycle is accepted, because the state is already IDLE. Throughput is one conversion per WIDTH+1 cycles.
- Output holding: bcd_out holds its last result between conversions and is unchanged while busy, so the display never shows intermediate values.
- Blanking (BLANK_LZ=1): scanning from digit DIGITS-1 down to digit 1, each digit equal to 0 becomes 4'hF until the first nonzero digit. Digit 0 always shows its true value.
- Width rules:
  - the add-3 is on 4-bit digits only and never carries into the neighbouring digit;
  - the counter width is $clog2(WIDTH+1);
  - the scratch register width is 4*DIGITS;
  - bits shifted out of the top of scratch are discarded. This is impossible when the DIGITS constraint holds.
- Reset mid-conversion: the operation aborts immediately, all registers go to their reset values, and no done pulse is issued.

Decomposition:
- Shared package bcd_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1;
  - BCD_BLANK=4'hF;
  - digit width constant 4.
- One sub-module, bcd_add3: combinational 4-bit in/out, returning in+3 when in>=5, else in. Instantiated DIGITS times with a generate loop.
- FSM, counter, blanking and output register stay in the top module.

Test Plan:
- Reset, then start with bin_in=16'd1234 → done pulse exactly 16 cycles after the accepting edge; bcd_out=20'hF1234 (digit 4 blanked); busy high 16 cycles.
- bin_in=16'hFFFF → bcd_out=20'h65535. bin_in=0 → bcd_out=20'hFFFF0. With BLANK_LZ=0, bin_in=0 → 20'h00000.
- Start with 16'd9, hold start high, and change bin_in to 16'd77 on the next 5 cycles → result 20'hFFFF9; only one done pulse.
- Back-to-back: start=1 during the done cycle with bin_in=16'd100 → second done 17 cycles after the first; bcd_out=20'hFF100.
- Start 16'd4321, assert rst_n low at cycle 8 → busy=0, done=0, bcd_out=0 asynchronously; no done after release. A new start then converts correctly.
- Exhaustive sweep 0..65535 with a scoreboard comparing against a reference decimal model; bcd_out stable whenever busy=1.
